// File: rtl/pipe_hazard_ctrl_ysyx_23060136.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_ysyx_23060136
//
// Central stall/flush controller for the five-stage core. It drives every
// hold and bubble strobe used by the IF/ID, ID/EX, EX/MEM and MEM/WB segment
// registers:
//   * load-use hazard between the load in EX and its consumer in ID,
//   * branch redirects resolved in EX (deferred while the LSU is busy),
//   * whole-pipeline hold while a multi-cycle LSU access is outstanding.
// The strobes are mutually qualified, so a segment register never sees a
// flush and a stall for itself in the same cycle.
//
// Ports
//   clk, rst                     core clock, synchronous active-high reset
//   IDU_rs1/rs2, IDU_use_rs1/rs2 source registers of the ID instruction
//   EXU_rd, EXU_write_gpr,       destination / write / load flags of the
//   EXU_mem_to_reg                 EX instruction
//   BRANCH_taken                 one-cycle redirect pulse from EX
//   LSU_req, LSU_done            MEM-stage access request / completion pulse
//   stallIF/ID/EX/MEM            hold PC, IF/ID, ID/EX, EX/MEM
//   flushIF/ID/MEM               bubble into IF/ID, ID/EX, MEM/WB
//   stall_cycles                 count of cycles with stallIF=1 (wrapping)
//   flush_events                 count of applied redirects (wrapping)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl_ysyx_23060136 #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IDU_rs1,
  input  logic [4:0]       IDU_rs2,
  input  logic             IDU_use_rs1,
  input  logic             IDU_use_rs2,
  input  logic [4:0]       EXU_rd,
  input  logic             EXU_write_gpr,
  input  logic             EXU_mem_to_reg,
  input  logic             BRANCH_taken,
  input  logic             LSU_req,
  input  logic             LSU_done,
  output logic             stallIF,
  output logic             stallID,
  output logic             stallEX,
  output logic             stallMEM,
  output logic             flushIF,
  output logic             flushID,
  output logic             flushMEM,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lsu_state_t;

  lsu_state_t state;
  lsu_state_t state_next;

  logic mem_busy;
  logic load_use;
  logic branch_pend;
  logic branch_any;
  logic redirect;

  // A load in EX whose result is read by the instruction in ID. x0 is never
  // a real dependency because writes to it are discarded.
  function automatic logic detect_load_use(
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       use_rs1,
    input logic       use_rs2,
    input logic [4:0] rd,
    input logic       write_gpr,
    input logic       mem_to_reg
  );
    logic hit1;
    logic hit2;
    hit1 = use_rs1 && (rs1 == rd);
    hit2 = use_rs2 && (rs2 == rd);
    return mem_to_reg && write_gpr && (rd != 5'd0) && (hit1 || hit2);
  endfunction

  // ---- LSU FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---- LSU FSM: next-state logic ----
  // A request completing in the same cycle it is presented is a zero-wait
  // access and never leaves IDLE. Once in WAIT only LSU_done releases the
  // FSM, even if LSU_req drops, so an access is never abandoned.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (LSU_req && !LSU_done) state_next = WAIT;
      WAIT:    if (LSU_done)             state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  // ---- LSU FSM: output logic ----
  always_comb begin
    mem_busy = 1'b0;
    case (state)
      IDLE:    mem_busy = LSU_req && !LSU_done;
      WAIT:    mem_busy = !LSU_done;
      default: mem_busy = 1'b0;
    endcase
  end

  assign load_use = detect_load_use(IDU_rs1, IDU_rs2, IDU_use_rs1, IDU_use_rs2,
                                    EXU_rd, EXU_write_gpr, EXU_mem_to_reg);

  // A redirect seen while memory is busy is remembered and applied in the
  // cycle mem_busy falls. Further pulses during the wait merge into the same
  // pending redirect, so only one flush is ever issued for them.
  assign branch_any = BRANCH_taken || branch_pend;
  assign redirect   = branch_any && !mem_busy;

  // ---- pending-branch register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_pend <= 1'b0;
    end else begin
      branch_pend <= branch_any && mem_busy;
    end
  end

  // ---- stall/flush resolution ----
  // Priority: memory hold > redirect > load-use. A redirect wins over a
  // load-use because the dependent instruction is squashed anyway. flushID is
  // never raised together with stallEX, so ID/EX can give its flush priority
  // over its own load without conflict.
  always_comb begin
    stallIF  = 1'b0;
    stallID  = 1'b0;
    stallEX  = 1'b0;
    stallMEM = 1'b0;
    flushIF  = 1'b0;
    flushID  = 1'b0;
    flushMEM = 1'b0;
    if (!rst) begin
      if (mem_busy) begin
        stallIF  = 1'b1;
        stallID  = 1'b1;
        stallEX  = 1'b1;
        stallMEM = 1'b1;
        flushMEM = 1'b1;
      end else if (redirect) begin
        flushIF  = 1'b1;
        flushID  = 1'b1;
      end else if (load_use) begin
        stallIF  = 1'b1;
        stallID  = 1'b1;
        flushID  = 1'b1;
      end
    end
  end

  // ---- performance counters ----
  // Both wrap naturally at 2^CNT_W. The redirect term is gated with rst so
  // nothing is counted while reset holds the outputs low.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stallIF) begin
        stall_cycles <= stall_cycles + CNT_ONE;
      end
      if (redirect) begin
        flush_events <= flush_events + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl_ysyx_23060136.sv
module tb_pipe_hazard_ctrl_ysyx_23060136;

  localparam int CNT_W = 32;

  // Expected output vector order: {stallIF,stallID,stallEX,stallMEM,flushIF,flushID,flushMEM}
  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] LU    = 7'b1100010;
  localparam logic [6:0] REDIR = 7'b0000110;
  localparam logic [6:0] BUSY  = 7'b1111001;

  logic             clk;
  logic             rst;
  logic [4:0]       IDU_rs1;
  logic [4:0]       IDU_rs2;
  logic             IDU_use_rs1;
  logic             IDU_use_rs2;
  logic [4:0]       EXU_rd;
  logic             EXU_write_gpr;
  logic             EXU_mem_to_reg;
  logic             BRANCH_taken;
  logic             LSU_req;
  logic             LSU_done;
  logic             stallIF;
  logic             stallID;
  logic             stallEX;
  logic             stallMEM;
  logic             flushIF;
  logic             flushID;
  logic             flushMEM;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];

  pipe_hazard_ctrl_ysyx_23060136 #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .IDU_rs1        (IDU_rs1),
    .IDU_rs2        (IDU_rs2),
    .IDU_use_rs1    (IDU_use_rs1),
    .IDU_use_rs2    (IDU_use_rs2),
    .EXU_rd         (EXU_rd),
    .EXU_write_gpr  (EXU_write_gpr),
    .EXU_mem_to_reg (EXU_mem_to_reg),
    .BRANCH_taken   (BRANCH_taken),
    .LSU_req        (LSU_req),
    .LSU_done       (LSU_done),
    .stallIF        (stallIF),
    .stallID        (stallID),
    .stallEX        (stallEX),
    .stallMEM       (stallMEM),
    .flushIF        (flushIF),
    .flushID        (flushID),
    .flushMEM       (flushMEM),
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    IDU_rs1        = 5'd0;
    IDU_rs2        = 5'd0;
    IDU_use_rs1    = 1'b0;
    IDU_use_rs2    = 1'b0;
    EXU_rd         = 5'd0;
    EXU_write_gpr  = 1'b0;
    EXU_mem_to_reg = 1'b0;
    BRANCH_taken   = 1'b0;
    LSU_req        = 1'b0;
    LSU_done       = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    EXU_rd         = rd;
    EXU_mem_to_reg = 1'b1;
    EXU_write_gpr  = 1'b1;
    IDU_rs2        = 5'd5;
    IDU_use_rs2    = 1'b1;
  endtask

  // Inputs are already driven (just after a posedge). Push the expectation,
  // sample on the falling edge, then advance past the next rising edge.
  task automatic cycle(input string tag, input logic [6:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    chk(e.tag, {57'd0, stallIF, stallID, stallEX, stallMEM, flushIF, flushID, flushMEM},
        {57'd0, e.exp});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int exp_stall, input int exp_flush);
    chk({tag, "_stall_cycles"}, 64'(stall_cycles), 64'(exp_stall));
    chk({tag, "_flush_events"}, 64'(flush_events), 64'(exp_flush));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;

    // Reset: active inputs are ignored, outputs stay low.
    set_load_use(5'd5);
    BRANCH_taken = 1'b1;
    LSU_req      = 1'b1;
    cycle("reset_out", NONE);
    rst = 1'b0;
    clear_inputs();
    chk_cnt("reset", 0, 0);
    cycle("idle", NONE);

    // Load-use hazard, then the same with rd=x0.
    set_load_use(5'd5);
    cycle("load_use", LU);
    chk_cnt("load_use", 1, 0);
    set_load_use(5'd0);
    cycle("load_use_x0", NONE);
    clear_inputs();

    // Branch overrides a simultaneous load-use.
    set_load_use(5'd5);
    BRANCH_taken = 1'b1;
    cycle("branch_lu", REDIR);
    clear_inputs();
    chk_cnt("branch", 1, 1);
    cycle("branch_after", NONE);

    // Four-cycle LSU access, done on the fourth.
    LSU_req = 1'b1;
    cycle("lsu_w1", BUSY);
    cycle("lsu_w2", BUSY);
    cycle("lsu_w3", BUSY);
    LSU_done = 1'b1;
    cycle("lsu_done", NONE);
    clear_inputs();
    chk_cnt("lsu", 4, 1);
    cycle("lsu_after", NONE);

    // Deferred redirect with a merged second pulse.
    LSU_req = 1'b1;
    BRANCH_taken = 1'b1;
    cycle("defer_c1", BUSY);
    cycle("defer_c2", BUSY);
    BRANCH_taken = 1'b0;
    LSU_done = 1'b1;
    cycle("defer_c3", REDIR);
    clear_inputs();
    cycle("defer_after", NONE);
    chk_cnt("defer", 6, 2);

    // Zero-wait access stays in IDLE.
    LSU_req  = 1'b1;
    LSU_done = 1'b1;
    cycle("zero_wait", NONE);
    clear_inputs();
    cycle("zero_wait_after", NONE);

    // LSU_req drops mid-wait: still busy until LSU_done.
    LSU_req = 1'b1;
    cycle("reqdrop_c1", BUSY);
    LSU_req = 1'b0;
    cycle("reqdrop_c2", BUSY);
    LSU_done = 1'b1;
    cycle("reqdrop_done", NONE);
    clear_inputs();
    chk_cnt("reqdrop", 8, 2);

    // Reset while waiting with a pending branch.
    LSU_req = 1'b1;
    BRANCH_taken = 1'b1;
    cycle("rstmid_busy", BUSY);
    BRANCH_taken = 1'b0;
    chk_cnt("rstmid_pre", 9, 2);
    rst = 1'b1;
    cycle("rstmid_out", NONE);
    rst = 1'b0;
    clear_inputs();
    cycle("rstmid_after1", NONE);
    chk_cnt("rstmid", 0, 0);
    cycle("rstmid_after2", NONE);

    if (sb_q.size() != 0) begin
      chk("sb_leftover", 64'(sb_q.size()), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl_ysyx_23060136.md
# pipe_hazard_ctrl_ysyx_23060136

Central stall/flush controller for the five-stage core. It generates every stall and flush strobe consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB segment registers. It detects load-use hazards, applies branch redirects, and holds the whole pipeline while a multi-cycle LSU access is outstanding. Outputs are already qualified, so a segment register never sees a flush and a stall for itself in the same cycle.

## Interface
Parameters:
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- IDU_rs1 / IDU_rs2  in  5 each  source registers of the instruction in ID
- IDU_use_rs1 / IDU_use_rs2  in  1 each  instruction in ID reads that source
- EXU_rd  in  5  destination of the instruction in EX
- EXU_write_gpr  in  1  instruction in EX writes a GPR
- EXU_mem_to_reg  in  1  instruction in EX is a load
- BRANCH_taken  in  1  single-cycle pulse: redirect resolved in EX
- LSU_req  in  1  MEM stage holds a load/store
- LSU_done  in  1  pulse: current LSU access completes
- stallIF / stallID / stallEX / stallMEM  out  1 each  hold PC, IF/ID, ID/EX, EX/MEM
- flushIF  out  1  load bubble into IF/ID
- flushID  out  1  load bubble into ID/EX
- flushMEM  out  1  load bubble into MEM/WB
- stall_cycles  out  CNT_W  cycles with stallIF=1
- flush_events  out  CNT_W  redirects applied

## Operation
- LSU FSM states: IDLE, WAIT.
  - IDLE→WAIT when LSU_req & ~LSU_done.
  - WAIT→IDLE on LSU_done.
  - A LSU_done in IDLE with LSU_req means a zero-wait access. The FSM stays in IDLE.
- mem_busy = (IDLE & LSU_req & ~LSU_done) | (WAIT & ~LSU_done).
- load_use = EXU_mem_to_reg & EXU_write_gpr & (EXU_rd≠0) & ((IDU_use_rs1 & IDU_rs1==EXU_rd) | (IDU_use_rs2 & IDU_rs2==EXU_rd)).
- Register branch_pend: next = (BRANCH_taken | branch_pend) & mem_busy.
- redirect = (BRANCH_taken | branch_pend) & ~mem_busy.
- Outputs are resolved in priority order. Exactly one row applies each cycle:
  1. mem_busy: stallIF=stallID=stallEX=stallMEM=1, flushMEM=1, all other flushes 0.
  2. redirect: flushIF=1, flushID=1, all stalls 0. The redirect overrides load_use because the dependent instruction is squashed.
  3. load_use: stallIF=1, stallID=1, flushID=1, stallEX=stallMEM=0.
  4. Otherwise all outputs are 0.
- The ID/EX register must treat flushID as higher priority than its own data load. The controller never asserts flushID together with stallEX.
- Counters:
  - stall_cycles increments by 1 in every cycle with stallIF=1.
  - flush_events increments by 1 in every cycle with redirect=1.
  - Both wrap modulo 2^CNT_W.

## Timing
- Stall/flush outputs are combinational from the inputs and the registered state. Latency is 0 cycles.
- State (FSM, branch_pend, counters) updates on posedge clk.
- While rst=1:
  - All stall/flush outputs are 0 and inputs are ignored.
  - At the next edge: FSM=IDLE, branch_pend=0, stall_cycles=0, flush_events=0.
- Reset asserted mid-access or mid-pending-branch discards both. The first cycle after reset behaves as IDLE with no pending branch.
- A load-use stall lasts exactly 1 cycle: after the bubble, the load sits in MEM and its data is forwarded.
- A redirect during an LSU wait is deferred. The flush fires in the same cycle mem_busy falls, which is the LSU_done cycle, and only once.
- A second BRANCH_taken while branch_pend=1 merges; it does not produce a second flush.
- LSU_req deasserting in WAIT without LSU_done returns mem_busy=1 until LSU_done. The FSM never abandons an access.

## Test plan
- Load-use: EXU_rd=5, EXU_mem_to_reg=1, EXU_write_gpr=1, IDU_rs2=5, IDU_use_rs2=1 → one cycle of stallIF=stallID=flushID=1, stallEX=0. Repeat with EXU_rd=0 → no stall.
- Branch: BRANCH_taken pulse, no LSU_req → flushIF=flushID=1 for 1 cycle, flush_events 0→1. The same cycle with a load_use match still gives stallIF=0.
- LSU wait: LSU_req=1 for 4 cycles, LSU_done on the 4th → stalls and flushMEM=1 in cycles 1–3, all 0 in cycle 4, stall_cycles=3.
- Deferred redirect: BRANCH_taken in cycle 1 of a 3-cycle LSU wait, plus a second pulse in cycle 2 → no flush in cycles 1–2, a single flushIF/flushID in cycle 3, flush_events=1.
- Zero-wait access: LSU_req=LSU_done=1 in the same cycle → no stall, FSM stays IDLE.
- Reset mid-WAIT with branch_pend=1 → outputs 0 during reset. After release with LSU_req=0 there is no stall or flush, and counters read 0.
